prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the instruction-memory interface. Receives a program as a byte stream over a
//  valid/ready handshake and assembles 32-bit little-endian words. Writes them into instruction
//  memory at byte addresses 0, 4, 8, ... and holds the multicycle CPU (state machine, PC) in
//  reset until the load completes. Replaces bench-side instruction injection.
// PARAMETERS
//  ADDR_W  8   imem byte-address width; capacity DEPTH = 2**(ADDR_W-2) words
//  LEN_W   16  width of the word-count header field
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       1-cycle pulse: begin or restart a load
//  byte_in      in   8       stream data byte
//  byte_valid   in   1       byte_in valid
//  byte_ready   out  1       loader accepts byte this cycle
//  imem_we      out  1       instruction-memory write enable (1 cycle per word)
//  imem_addr    out  ADDR_W  instruction-memory byte address (word aligned)
//  imem_din     out  32      instruction word
//  cpu_hold     out  1       1 = hold CPU in reset
//  done         out  1       load finished without error (level)
//  err          out  1       load aborted (level)
// BEHAVIOUR
//  Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_din=0, cpu_hold=1, done=0, err=0, state=IDLE.
//  Handshake: a byte transfers on a rising edge where byte_valid & byte_ready = 1.
//    byte_ready=1 only in LEN_LO, LEN_HI, COLLECT (and CHK if enabled).
//  Frame: LEN_LO, LEN_HI (word count N, little-endian), then 4*N instruction bytes, LSB first.
//  FSM:
//    IDLE    -start-> LEN_LO; clears done/err, cpu_hold=1, imem_addr=0
//    LEN_LO  -xfer-> LEN_HI
//    LEN_HI  -xfer-> N==0 ? FIN : N>DEPTH ? ERR : COLLECT
//    COLLECT -4th xfer of word-> WRITE; 2-bit byte counter, bytes shift in at [31:24]
//    WRITE   1 cycle: imem_we=1, imem_din=word, imem_addr=4*k
//            -> last word ? FIN : COLLECT; imem_addr += 4 after the write
//    FIN     -> DONE (or CHK, see CONFIGURATION)
//    DONE    done=1, cpu_hold=0; -start-> LEN_LO
//    ERR     err=1, cpu_hold=1, byte_ready=0; -start-> LEN_LO
//  Latency: imem_we asserts 1 cycle after the 4th byte of a word is accepted.
//    Throughput: 1 byte/cycle except one stall cycle per word (WRITE).
//  start is ignored in LEN_LO..FIN; it is only honoured in IDLE, DONE and ERR.
//  Byte offered in the same cycle as start is not accepted (byte_ready still 0).
//  imem_addr wraps never: N>DEPTH is rejected before any write.
//    N==DEPTH fills the memory exactly, last address 4*(DEPTH-1).
//  Reset mid-load: everything returns to reset values at once. Partially written words stay in
//    imem; cpu_hold stays 1.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//    FIN -> CHK; one extra trailing byte is accepted.
//    If it equals the XOR of all header and program bytes -> DONE, else -> ERR.
//  Not defined: no trailing byte; FIN -> DONE directly; err only from N>DEPTH.
// STRUCTURE
//  prog_loader_defs.vh (shared `include): state encodings
//    (IDLE, LEN_LO, LEN_HI, COLLECT, WRITE, FIN, CHK, DONE, ERR as 4-bit localparams),
//    WORD_W=32, BYTES_PER_WORD=4.
//  Sub-module word_assembler: 8->32 shift register plus 2-bit byte counter.
//    Outputs word and word_full.
// TESTING
//  1 word: start, bytes 02 00 00 00 ... ; use N=1, bytes 33 00 B5 00 -> one imem_we,
//    imem_addr=0, imem_din=32'h00B50033, done=1, cpu_hold=0.
//  N=3 back-to-back valid -> writes at addr 0, 4, 8.
//    byte_ready low exactly 1 cycle after each 4th byte; done after 3rd write.
//  N=0 (00 00) -> no imem_we, done=1 two cycles after LEN_HI.
//  N=DEPTH+1 (ADDR_W=8: 41 00) -> err=1, byte_ready=0, no imem_we.
//    start then N=1 recovers to done.
//  Reset asserted after 2 bytes of word 1 -> all outputs at reset values asynchronously.
//    New start and full frame load correctly from addr 0.
//  LOADER_CHECKSUM_EN, N=1 bytes 01 02 03 04, checksum byte 05 -> done.
//    Checksum byte 06 -> err=1, cpu_hold=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings, word geometry
// and a helper that tells which states take bytes from the stream.
package prog_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_LO  = 4'd1,
    ST_LEN_HI  = 4'd2,
    ST_COLLECT = 4'd3,
    ST_WRITE   = 4'd4,
    ST_FIN     = 4'd5,
    ST_CHK     = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } state_t;

  // True for states in which the loader offers byte_ready.
  function automatic logic accepts_bytes(input state_t st);
    return (st == ST_LEN_LO) || (st == ST_LEN_HI) ||
           (st == ST_COLLECT) || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// 8->32 bit little-endian word assembler: each accepted byte enters at the top
// of the shift register, so after four pushes the first byte sits in [7:0].
// word_full flags the push that completes a word.
module prog_loader_word_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [WORD_W-1:0] shift_r;
  logic [CNT_W-1:0]  cnt_r;

  // Shift register and byte counter; the counter wraps naturally after the last byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r <= {WORD_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r   <= {CNT_W{1'b0}};
    end else if (push) begin
      shift_r <= {byte_in, shift_r[WORD_W-1:8]};
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

  assign word_full = push && (cnt_r == CNT_W'(BYTES_PER_WORD - 1));
  assign word      = shift_r;

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream, assembles 32-bit
// little-endian words, writes them to instruction memory from address 0 and
// keeps the CPU in reset until the load has completed.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte covering header and program bytes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(2 ** (ADDR_W - 2));

  state_t            state_r;
  state_t            state_next_s;
  logic              xfer_s;
  logic              start_ok_s;
  logic              push_s;
  logic              word_full_s;
  logic [LEN_W-1:0]  len_s;
  logic [7:0]        len_lo_r;
  logic [LEN_W-1:0]  rem_r;
  logic [ADDR_W-1:0] addr_r;
  logic              byte_ready_r;
  logic              imem_we_r;
  logic              cpu_hold_r;
  logic              done_r;
  logic              err_r;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_r;
`endif

  assign xfer_s     = byte_valid && byte_ready_r;
  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                (state_r == ST_ERR));
  assign push_s     = xfer_s && (state_r == ST_COLLECT);
  assign len_s      = LEN_W'({byte_in, len_lo_r});

  prog_loader_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok_s),
    .push      (push_s),
    .byte_in   (byte_in),
    .word      (imem_din),
    .word_full (word_full_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start is honoured only in IDLE, DONE and ERR.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_next_s = ST_LEN_LO;
        else       state_next_s = state_r;
      end
      ST_LEN_LO: begin
        if (xfer_s) state_next_s = ST_LEN_HI;
        else        state_next_s = ST_LEN_LO;
      end
      ST_LEN_HI: begin
        if (!xfer_s)                           state_next_s = ST_LEN_HI;
        else if (len_s == LEN_W'(0))           state_next_s = ST_FIN;
        else if ({1'b0, len_s} > DEPTH_L)      state_next_s = ST_ERR;
        else                                   state_next_s = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (word_full_s) state_next_s = ST_WRITE;
        else             state_next_s = ST_COLLECT;
      end
      ST_WRITE: begin
        if (rem_r == LEN_W'(1)) state_next_s = ST_FIN;
        else                    state_next_s = ST_COLLECT;
      end
      ST_FIN: begin
`ifdef LOADER_CHECKSUM_EN
        state_next_s = ST_CHK;
`else
        state_next_s = ST_DONE;
`endif
      end
      ST_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (!xfer_s)                state_next_s = ST_CHK;
        else if (byte_in == csum_r) state_next_s = ST_DONE;
        else                        state_next_s = ST_ERR;
`else
        state_next_s = ST_ERR;
`endif
      end
      default: state_next_s = ST_ERR;
    endcase
  end

  // Datapath: length capture, remaining-word count, write address and checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_lo_r <= 8'h00;
      rem_r    <= {LEN_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
`ifdef LOADER_CHECKSUM_EN
      csum_r   <= 8'h00;
`endif
    end else if (start_ok_s) begin
      rem_r    <= {LEN_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
`ifdef LOADER_CHECKSUM_EN
      csum_r   <= 8'h00;
`endif
    end else begin
`ifdef LOADER_CHECKSUM_EN
      if (xfer_s && (state_r != ST_CHK)) csum_r <= csum_r ^ byte_in;
`endif
      if (xfer_s && (state_r == ST_LEN_LO)) len_lo_r <= byte_in;
      if (xfer_s && (state_r == ST_LEN_HI)) rem_r    <= len_s;
      if (state_r == ST_WRITE) begin
        addr_r <= addr_r + ADDR_W'(4);
        rem_r  <= rem_r - LEN_W'(1);
      end
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_ready_r <= 1'b0;
      imem_we_r    <= 1'b0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      byte_ready_r <= accepts_bytes(state_next_s);
      imem_we_r    <= (state_next_s == ST_WRITE);
      cpu_hold_r   <= (state_next_s != ST_DONE);
      done_r       <= (state_next_s == ST_DONE);
      err_r        <= (state_next_s == ST_ERR);
    end
  end

  assign byte_ready = byte_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = addr_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (ADDR_W=8 -> 64-word memory).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_din;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [31:0] last_data = 32'h0;
  logic [7:0]  csum_tb = 8'h00;

  prog_loader #(.ADDR_W(8), .LEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_din   (imem_din),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Record every instruction-memory write.
  always @(posedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = imem_addr;
      last_data = imem_din;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte, wait (bounded) for ready, let it transfer; valid stays high.
  task automatic send_byte(input logic [7:0] b);
    int k;
    byte_in    = b;
    byte_valid = 1'b1;
    k = 0;
    while (byte_ready !== 1'b1 && k < 40) begin
      tick();
      k = k + 1;
    end
    if (k >= 40) begin
      n_fail = n_fail + 1;
      $error("FAIL ready_timeout: observed byte_ready=0 expected 1 within 40 cycles");
    end
    csum_tb = csum_tb ^ b;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[7:0]);
      v = v >> 8;
    end
  endtask

  task automatic start_load();
    csum_tb = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Optional checksum byte, then bounded wait for done or err.
  task automatic finish_load();
    int k;
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum_tb);
`endif
    byte_valid = 1'b0;
    k = 0;
    while (done !== 1'b1 && err !== 1'b1 && k < 20) begin
      tick();
      k = k + 1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_we"},    {31'd0, imem_we},    32'd0);
    check({tag, "_addr"},  {24'd0, imem_addr},  32'd0);
    check({tag, "_din"},   imem_din,            32'd0);
    check({tag, "_hold"},  {31'd0, cpu_hold},   32'd1);
    check({tag, "_done"},  {31'd0, done},       32'd0);
    check({tag, "_err"},   {31'd0, err},        32'd0);
  endtask

  initial begin
    int w0;
    logic [31:0] words [3];
    words[0] = 32'h11223344;
    words[1] = 32'hA5A50F0F;
    words[2] = 32'hDEADBEEF;

    // Reset state
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();

    // N=1, bytes 33 00 B5 00; a byte offered with start is not taken
    w0 = wr_cnt;
    byte_in = 8'h01;
    byte_valid = 1'b1;
    start_load();
    check("t1_ready_after_start", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h00B50033);
    check("t1_we",   {31'd0, imem_we},   32'd1);
    check("t1_addr", {24'd0, imem_addr}, 32'd0);
    check("t1_din",  imem_din,           32'h00B50033);
    finish_load();
    check("t1_done", {31'd0, done},       32'd1);
    check("t1_hold", {31'd0, cpu_hold},   32'd0);
    check("t1_nwr",  wr_cnt - w0,         32'd1);

    // N=3 back-to-back: one stall cycle per word
    w0 = wr_cnt;
    start_load();
    check("t2_done_cleared", {31'd0, done}, 32'd0);
    check("t2_hold_set",     {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h03);
    send_byte(8'h00);
    for (int w = 0; w < 3; w++) begin
      send_word(words[w]);
      check("t2_we",    {31'd0, imem_we},    32'd1);
      check("t2_stall", {31'd0, byte_ready}, 32'd0);
      check("t2_addr",  {24'd0, imem_addr},  32'(4 * w));
      check("t2_din",   imem_din,            words[w]);
      if (w < 2) begin
        tick();
        check("t2_ready_back", {31'd0, byte_ready}, 32'd1);
      end
    end
    finish_load();
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_nwr",  wr_cnt - w0,   32'd3);

    // N=0: no writes, done two edges after the LEN_HI byte
    w0 = wr_cnt;
    start_load();
    send_byte(8'h00);
    send_byte(8'h00);
`ifndef LOADER_CHECKSUM_EN
    byte_valid = 1'b0;
    check("t3_done_fin", {31'd0, done}, 32'd0);
    tick();
    check("t3_done", {31'd0, done}, 32'd1);
`else
    finish_load();
    check("t3_done", {31'd0, done}, 32'd1);
`endif
    check("t3_nwr", wr_cnt - w0, 32'd0);

    // N=DEPTH+1 rejected
    w0 = wr_cnt;
    start_load();
    send_byte(8'h41);
    send_byte(8'h00);
    byte_valid = 1'b0;
    check("t4_err",   {31'd0, err},        32'd1);
    check("t4_ready", {31'd0, byte_ready}, 32'd0);
    check("t4_hold",  {31'd0, cpu_hold},   32'd1);
    check("t4_done",  {31'd0, done},       32'd0);
    tick();
    check("t4_nwr",   wr_cnt - w0,         32'd0);
    // Recovery
    start_load();
    check("t4_err_cleared", {31'd0, err}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hCAFEF00D);
    check("t4r_din", imem_din, 32'hCAFEF00D);
    finish_load();
    check("t4r_done", {31'd0, done}, 32'd1);

    // N=DEPTH fills memory exactly
    w0 = wr_cnt;
    start_load();
    send_byte(8'h40);
    send_byte(8'h00);
    for (int w = 0; w < 64; w++) begin
      send_word({8'(w), 8'h5A, 8'(w), 8'hC3});
    end
    finish_load();
    check("t5_done",      {31'd0, done},      32'd1);
    check("t5_err",       {31'd0, err},       32'd0);
    check("t5_nwr",       wr_cnt - w0,        32'd64);
    check("t5_last_addr", {24'd0, last_addr}, 32'h000000FC);
    check("t5_last_data", last_data,          32'h3F5A3FC3);

    // Asynchronous reset mid-load, then a clean load from address 0
    start_load();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h77);
    send_byte(8'h66);
    byte_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("amid");
    tick();
    reset = 1'b0;
    tick();
    w0 = wr_cnt;
    start_load();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h01234567);
    check("t6_addr", {24'd0, imem_addr}, 32'd0);
    check("t6_din",  imem_din,           32'h01234567);
    finish_load();
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_nwr",  wr_cnt - w0,   32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum: 01 00 01 02 03 04 xor = 05
    start_load();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h04030201);
    send_byte(8'h05);
    byte_valid = 1'b0;
    tick();
    check("t7_done", {31'd0, done}, 32'd1);
    start_load();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h04030201);
    send_byte(8'h06);
    byte_valid = 1'b0;
    tick();
    check("t7_err",  {31'd0, err},      32'd1);
    check("t7_hold", {31'd0, cpu_hold}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
